// File: rtl/calc_pkg.sv
// calc_pkg: shared glyph codes, FSM states and seven-segment table for the calculator display
package calc_pkg;
  typedef enum logic [3:0] {D0, D1, D2, D3, D4, D5, D6, D7, D8, D9, MINUS, O, F, BLANK} glyph_t;
  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;
  localparam logic [6:0] SEG7 [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b1000000, 7'b0001110, 7'b1111111, 7'b1111111, 7'b1111111
  };
  function automatic logic [3:0] dd_fix(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/calc_result_display_if.sv
// calc_result_display_if: result capture and display pin bundle
interface calc_result_display_if #(parameter int WIDTH = 4);
  logic ld;
  logic [WIDTH-1:0] r;
  logic ovf;
  logic busy;
  logic [3:0] an;
  logic [6:0] seg;
  modport master (output ld, r, ovf, input busy, an, seg);
  modport slave (input ld, r, ovf, output busy, an, seg);
endinterface

// File: rtl/calc_seg7_glyph.sv
// calc_seg7_glyph: glyph code to active-low segment pattern
module calc_seg7_glyph
  import calc_pkg::*;
(
  input glyph_t g,
  output logic [6:0] seg
);
  assign seg = SEG7[g];
endmodule

// File: rtl/calc_result_display.sv
// calc_result_display: captures a signed result, converts it to sign plus BCD, scans a 4-digit display
module calc_result_display
  import calc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic rst,
  calc_result_display_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int NW = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [NW-1:0] cnt;
  logic [WIDTH-1:0] sh, mag;
  logic [11:0] bcd, adj;
  logic neg, ovf_l, done, show_h, show_t, wrap;
  glyph_t dig [4];
  glyph_t nd [4];
  logic [CW-1:0] scnt;
  logic [1:0] idx;
  logic [6:0] gseg;
  // modulo-2^WIDTH negation yields the correct unsigned magnitude even for -2^(WIDTH-1)
  assign mag = bus.r[WIDTH-1] ? -bus.r : bus.r;
  assign done = state == CONV && cnt == NW'(WIDTH);
  assign adj = {dd_fix(bcd[11:8]), dd_fix(bcd[7:4]), dd_fix(bcd[3:0])};
  assign bus.busy = state == CONV && cnt != '0;
  assign show_h = bcd[11:8] != 4'd0;
  assign show_t = show_h || bcd[7:4] != 4'd0;
  assign wrap = scnt == CW'(REFRESH_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (bus.ld) state_n = CONV;
    else if (done) state_n = SHOW;
  end
  always_comb begin
    nd[0] = ovf_l ? F : glyph_t'(bcd[3:0]);
    nd[1] = ovf_l ? O : show_t ? glyph_t'(bcd[7:4]) : neg ? MINUS : BLANK;
    nd[2] = ovf_l ? BLANK : show_h ? glyph_t'(bcd[11:8]) : neg && show_t ? MINUS : BLANK;
    nd[3] = !ovf_l && neg && show_h ? MINUS : BLANK;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sh <= '0;
      bcd <= '0;
      neg <= 1'b0;
      ovf_l <= 1'b0;
      dig <= '{default: BLANK};
    end else if (bus.ld) begin
      cnt <= '0;
      sh <= mag;
      bcd <= '0;
      neg <= bus.r[WIDTH-1] && !bus.ovf;
      ovf_l <= bus.ovf;
    end else if (state == CONV) begin
      if (done) dig <= nd;
      else begin
        {bcd, sh} <= {adj, sh} << 1;
        cnt <= cnt + NW'(1);
      end
    end
  end
  calc_seg7_glyph u_glyph (.g(dig[idx]), .seg(gseg));
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
      idx <= 2'd0;
      bus.an <= 4'hf;
      bus.seg <= 7'h7f;
    end else begin
      scnt <= wrap ? '0 : scnt + CW'(1);
      if (wrap) idx <= idx + 2'd1;
      bus.an <= state == IDLE ? 4'hf : ~(4'b0001 << idx);
      bus.seg <= state == IDLE ? 7'h7f : gseg;
    end
  end
endmodule
